// File: rtl/dwrr_pkg.sv
// Shared definitions for the DWRR arbiter and its ingress queue bank.
// Both blocks import this package so that their NUM_REQS defaults agree.
package dwrr_pkg;

  localparam int NUM_REQS_DEF = 4;
  localparam int DEPTH_DEF    = 8;
  localparam int DWID_DEF     = 8;
  localparam int QIDWID_DEF   = $clog2(NUM_REQS_DEF);

  typedef logic [QIDWID_DEF-1:0] qid_t;

  // True when at most one bit is set. Callers zero-extend narrower grant vectors.
  function automatic logic onehot0_or_zero(input logic [31:0] v);
    return (v & (v - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/dwrr_ingress_queues_sync_fifo.sv
// Single-clock circular-buffer FIFO. Pointers wrap naturally at DEPTH.
// The caller is responsible for never pushing while full or popping while empty.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int DWID  = 8,
  localparam int PTRW   = $clog2(DEPTH),
  localparam int CNTWID = PTRW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWID-1:0]   wdata,
  input  logic              pop,
  output logic [DWID-1:0]   rdata,
  output logic [CNTWID-1:0] count,
  output logic              full,
  output logic              empty
);

  logic [DWID-1:0] mem [DEPTH];
  logic [PTRW-1:0] wptr;
  logic [PTRW-1:0] rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = (count == CNTWID'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/dwrr_ingress_queues.sv
// Per-requestor packet queues feeding the DWRR arbiter: drives reqs/blk,
// dequeues on a one-hot grant into a registered, queue-tagged output stage.
module dwrr_ingress_queues
  import dwrr_pkg::*;
#(
  parameter int NUM_REQS = NUM_REQS_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int DWID     = DWID_DEF,
  parameter int QIDWID   = $clog2(NUM_REQS),
  parameter int CNTWID   = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQS-1:0]      in_valid,
  input  logic [NUM_REQS*DWID-1:0] in_data,
  output logic [NUM_REQS-1:0]      in_ready,
  output logic [NUM_REQS-1:0]      reqs,
  input  logic [NUM_REQS-1:0]      gnt,
  output logic                     blk,
  output logic                     out_valid,
  output logic [DWID-1:0]          out_data,
  output logic [QIDWID-1:0]        out_qid,
  input  logic                     out_ready,
  output logic                     gnt_err
);

  logic [DWID-1:0]   rdata [NUM_REQS];
  logic [CNTWID-1:0] count [NUM_REQS];
  logic [NUM_REQS-1:0] full;
  logic [NUM_REQS-1:0] empty;
  logic [NUM_REQS-1:0] push;
  logic [NUM_REQS-1:0] pop;

  logic              gnt_single;
  logic              err_now;
  logic              pop_any;
  logic [QIDWID-1:0] pop_qid;
  logic [DWID-1:0]   pop_data;

  // in_ready looks only at the current count, so a full queue never accepts
  // a push even if it is being popped in the same cycle.
  assign in_ready = ~full & {NUM_REQS{~rst}};
  assign push     = in_valid & in_ready;

  // A stalled output register withdraws every request, so a pop can only
  // happen when the register is empty or draining this cycle.
  assign blk  = out_valid & ~out_ready;
  assign reqs = ~empty & {NUM_REQS{~blk}};

  assign gnt_single = onehot0_or_zero(32'(gnt));
  assign pop        = gnt_single ? (gnt & reqs) : '0;
  assign err_now    = ~gnt_single | (|(gnt & ~reqs));

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_q
    sync_fifo #(
      .DEPTH (DEPTH),
      .DWID  (DWID)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .wdata (in_data[i*DWID +: DWID]),
      .pop   (pop[i]),
      .rdata (rdata[i]),
      .count (count[i]),
      .full  (full[i]),
      .empty (empty[i])
    );

    assert property (@(posedge clk) disable iff (rst) count[i] <= CNTWID'(DEPTH));
  end

  always_comb begin
    pop_any  = |pop;
    pop_qid  = '0;
    pop_data = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (pop[i]) begin
        pop_qid  = QIDWID'(i);
        pop_data = rdata[i];
      end
    end
  end

  // Output stage: load on pop, clear when drained, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_qid   <= '0;
      gnt_err   <= 1'b0;
    end else begin
      if (pop_any) begin
        out_valid <= 1'b1;
        out_data  <= pop_data;
        out_qid   <= pop_qid;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      gnt_err <= gnt_err | err_now;
    end
  end

endmodule

// File: tb/tb_dwrr_ingress_queues.sv
// Self-checking bench for dwrr_ingress_queues: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_dwrr_ingress_queues;

  localparam int N = 4;
  localparam int D = 8;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic [N-1:0]  reqs;
  logic [N-1:0]  gnt;
  logic          blk;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    out_qid;
  logic          out_ready;
  logic          gnt_err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0] mq [0:N-1][$];
  logic         m_ov;
  logic [W-1:0] m_od;
  logic [1:0]   m_oq;
  logic         m_err;

  always #5 clk = ~clk;

  dwrr_ingress_queues #(
    .NUM_REQS (N),
    .DEPTH    (D),
    .DWID     (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reqs      (reqs),
    .gnt       (gnt),
    .blk       (blk),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_qid   (out_qid),
    .out_ready (out_ready),
    .gnt_err   (gnt_err)
  );

  function automatic logic [N-1:0] m_space();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (mq[i].size() < D);
    return r;
  endfunction

  function automatic logic [N-1:0] m_reqs(input logic ordy);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (mq[i].size() != 0) && !(m_ov && !ordy);
    return r;
  endfunction

  // Advance one clock and apply the rules to the model using the inputs seen at the edge.
  task automatic cycle();
    logic [N-1:0]   iv, g, mr, acc;
    logic [N*W-1:0] id;
    logic           r, ordy;
    int             gc, gi;
    iv = in_valid; g = gnt; id = in_data; r = rst; ordy = out_ready;
    mr  = m_reqs(ordy);
    acc = m_space() & iv;
    gc  = $countones(g);
    gi  = 0;
    for (int i = 0; i < N; i++) if (g[i]) gi = i;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_ov = 1'b0; m_od = '0; m_oq = '0; m_err = 1'b0;
    end else begin
      if (gc > 1 || (g & ~mr) != '0) m_err = 1'b1;
      if (gc == 1 && mr[gi]) begin
        m_od = mq[gi].pop_front();
        m_oq = gi[1:0];
        m_ov = 1'b1;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(id[i*W +: W]);
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_data = '0; gnt = '0; out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_inputs();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); in_valid = '1;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready_during got=%b exp=0000", in_ready); end
    cycle(); cycle();
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready_held got=%b exp=0000", in_ready); end
    rst = 1'b0; in_valid = '0;
    #1;
    checks++;
    if (in_ready !== 4'b1111 || reqs !== 4'b0000) begin
      errors++; $display("FAIL reset_after got in_ready=%b reqs=%b exp 1111/0000", in_ready, reqs);
    end
    checks++;
    if (out_valid !== 1'b0 || gnt_err !== 1'b0 || out_data !== 8'h00 || out_qid !== 2'd0) begin
      errors++; $display("FAIL reset_outputs got v=%b err=%b d=%h q=%0d exp 0/0/00/0", out_valid, gnt_err, out_data, out_qid);
    end
  endtask

  task automatic test_push_grant();
    in_valid = 4'b0100; in_data = '0; in_data[2*W +: W] = 8'hA5;
    cycle();
    in_valid = '0;
    #1;
    checks++;
    if (reqs !== 4'b0100) begin errors++; $display("FAIL push_reqs got=%b exp=0100", reqs); end
    gnt = 4'b0100;
    cycle();
    gnt = '0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_qid !== 2'd2) begin
      errors++; $display("FAIL grant_out got v=%b d=%h q=%0d exp 1/a5/2", out_valid, out_data, out_qid);
    end
    checks++;
    if (reqs !== 4'b0000) begin errors++; $display("FAIL grant_reqs_clear got=%b exp=0000", reqs); end
    cycle();
    checks++;
    if (out_valid !== 1'b0 || gnt_err !== 1'b0) begin
      errors++; $display("FAIL grant_drain got v=%b err=%b exp 0/0", out_valid, gnt_err);
    end
  endtask

  task automatic test_fill_wrap();
    logic [W-1:0] exp_seq [10];
    for (int k = 0; k < 8; k++) begin
      in_valid = 4'b0001; in_data = '0; in_data[W-1:0] = 8'h10 + W'(k);
      cycle();
    end
    in_valid = '0;
    #1;
    checks++;
    if (in_ready[0] !== 1'b0 || in_ready[3:1] !== 3'b111) begin
      errors++; $display("FAIL full_in_ready got=%b exp=1110", in_ready);
    end
    // Push attempted while full, with a pop in the same cycle: must be dropped.
    in_valid = 4'b0001; in_data[W-1:0] = 8'h99; gnt = 4'b0001;
    cycle();
    checks++;
    if (out_data !== 8'h10 || out_qid !== 2'd0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL full_pop got v=%b d=%h q=%0d exp 1/10/0", out_valid, out_data, out_qid);
    end
    for (int k = 0; k < 7; k++) exp_seq[k] = 8'h11 + W'(k);
    for (int k = 0; k < 3; k++) exp_seq[7+k] = 8'hE0 + W'(k);
    for (int k = 0; k < 10; k++) begin
      gnt = 4'b0001;
      in_valid = (k < 3) ? 4'b0001 : 4'b0000;
      in_data[W-1:0] = 8'hE0 + W'(k);
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_seq[k] || out_qid !== 2'd0) begin
        errors++; $display("FAIL wrap_order[%0d] got v=%b d=%h exp 1/%h", k, out_valid, out_data, exp_seq[k]);
      end
    end
    idle_inputs();
    cycle();
    checks++;
    if (reqs !== 4'b0000 || in_ready !== 4'b1111 || out_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_empty got reqs=%b rdy=%b v=%b exp 0000/1111/0", reqs, in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 4'b1000; in_data = '0; in_data[3*W +: W] = 8'h31;
    cycle();
    in_data[3*W +: W] = 8'h32;
    cycle();
    in_valid = '0; out_ready = 1'b0; gnt = 4'b1000;
    cycle();
    gnt = '0;
    #1;
    checks++;
    if (blk !== 1'b1 || reqs !== 4'b0000) begin
      errors++; $display("FAIL bp_blk got blk=%b reqs=%b exp 1/0000", blk, reqs);
    end
    cycle(); cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h31 || out_qid !== 2'd3) begin
      errors++; $display("FAIL bp_hold got v=%b d=%h q=%0d exp 1/31/3", out_valid, out_data, out_qid);
    end
    out_ready = 1'b1; gnt = 4'b1000;
    #1;
    checks++;
    if (blk !== 1'b0 || reqs !== 4'b1000) begin
      errors++; $display("FAIL bp_release got blk=%b reqs=%b exp 0/1000", blk, reqs);
    end
    cycle();
    gnt = '0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h32) begin
      errors++; $display("FAIL bp_next got v=%b d=%h exp 1/32", out_valid, out_data);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0 || gnt_err !== 1'b0) begin
      errors++; $display("FAIL bp_drain got v=%b err=%b exp 0/0", out_valid, gnt_err);
    end
  endtask

  task automatic test_simul_push_pop();
    in_valid = 4'b0010; in_data = '0; in_data[W +: W] = 8'h22;
    cycle();
    in_data[W +: W] = 8'h33; gnt = 4'b0010;
    cycle();
    in_valid = '0;
    #1;
    checks++;
    if (out_data !== 8'h22 || out_qid !== 2'd1 || reqs !== 4'b0010) begin
      errors++; $display("FAIL simul_pushpop got d=%h q=%0d reqs=%b exp 22/1/0010", out_data, out_qid, reqs);
    end
    cycle();
    gnt = '0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h33) begin
      errors++; $display("FAIL simul_next got v=%b d=%h exp 1/33", out_valid, out_data);
    end
    cycle();
    checks++;
    if (reqs !== 4'b0000 || out_valid !== 1'b0) begin
      errors++; $display("FAIL simul_empty got reqs=%b v=%b exp 0000/0", reqs, out_valid);
    end
  endtask

  task automatic test_errors();
    in_valid = 4'b0011; in_data = {8'h00, 8'h00, 8'h41, 8'h40};
    cycle();
    in_valid = '0; gnt = 4'b0011;
    cycle();
    gnt = '0;
    #1;
    checks++;
    if (gnt_err !== 1'b1 || out_valid !== 1'b0 || reqs !== 4'b0011) begin
      errors++; $display("FAIL err_multi got err=%b v=%b reqs=%b exp 1/0/0011", gnt_err, out_valid, reqs);
    end
    cycle(); cycle();
    checks++;
    if (gnt_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", gnt_err); end
    do_reset();
    #1;
    checks++;
    if (gnt_err !== 1'b0 || reqs !== 4'b0000) begin
      errors++; $display("FAIL err_rst_clear got err=%b reqs=%b exp 0/0000", gnt_err, reqs);
    end
    gnt = 4'b0100;
    cycle();
    gnt = '0;
    checks++;
    if (gnt_err !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL err_empty got err=%b v=%b exp 1/0", gnt_err, out_valid);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [N-1:0] mr;
    int           start;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      in_valid  = N'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 149) == 0);
      mr        = m_reqs(out_ready);
      gnt       = '0;
      if (mr != '0 && $urandom_range(0, 4) != 0) begin
        start = $urandom_range(0, N-1);
        for (int k = 0; k < N; k++) begin
          if (gnt == '0 && mr[(start + k) % N]) gnt[(start + k) % N] = 1'b1;
        end
      end
      #1;
      checks++;
      if (in_ready !== (rst ? 4'b0000 : m_space()) || reqs !== mr || blk !== (m_ov && !out_ready)) begin
        errors++; $display("FAIL rand_comb[%0d] got rdy=%b reqs=%b blk=%b exp %b/%b/%b", n, in_ready, reqs, blk,
                           (rst ? 4'b0000 : m_space()), mr, (m_ov && !out_ready));
      end
      cycle();
      checks++;
      if (out_valid !== m_ov || gnt_err !== m_err || (m_ov && (out_data !== m_od || out_qid !== m_oq))) begin
        errors++; $display("FAIL rand_out[%0d] got v=%b d=%h q=%0d err=%b exp %b/%h/%0d/%b", n, out_valid, out_data,
                           out_qid, gnt_err, m_ov, m_od, m_oq, m_err);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_ov = 1'b0; m_od = '0; m_oq = '0; m_err = 1'b0;
    test_reset();
    test_push_grant();
    test_fill_wrap();
    test_backpressure();
    test_simul_push_pop();
    test_errors();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
